// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals bundled between the arbiter and its environment.
interface alu_arbiter_if;
    localparam int unsigned W = 8;

    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [1:0]   req0_op;
    logic [1:0]   req1_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic [1:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_o;
    logic         alu_c;
    logic         alu_z;

    logic         rsp0_valid;
    logic         rsp1_valid;
    logic         rsp0_ready;
    logic         rsp1_ready;
    logic [W-1:0] rsp_o;
    logic         rsp_c;
    logic         rsp_z;
    logic         busy;

    // Environment side: requesters plus the combinational ALU
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        output alu_o, alu_c, alu_z, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
        input  rsp0_valid, rsp1_valid, rsp_o, rsp_c, rsp_z, busy
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        input  alu_o, alu_c, alu_z, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, alu_op, alu_a, alu_b,
        output rsp0_valid, rsp1_valid, rsp_o, rsp_c, rsp_z, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one 8-bit combinational ALU, one transaction in flight.
module alu_arbiter (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam int unsigned W = 8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state;
    state_t       state_nxt;
    logic         ptr;
    logic         gid;
    logic         gnt;
    logic         rdy0;
    logic         rdy1;
    logic         accept;
    logic         rsp_hs;
    logic [1:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] rsp_o_q;
    logic         rsp_c_q;
    logic         rsp_z_q;

    // Grant selection: sole requester wins, ptr breaks ties
    always_comb begin
        gnt = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt = ptr;
        end else if (bus.req1_valid) begin
            gnt = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake strobes; ready is masked during reset so it never leaks out
    always_comb begin
        state_nxt = state;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                rdy0 = !rst && bus.req0_valid && !gnt;
                rdy1 = !rst && bus.req1_valid && gnt;
                if (rdy0 || rdy1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_hs = gid ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = rdy0 || rdy1;

    // Operand/grant capture on accept, result capture in EXEC, pointer update on response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= 1'b0;
            gid     <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= W'(0);
            b_q     <= W'(0);
            rsp_o_q <= W'(0);
            rsp_c_q <= 1'b0;
            rsp_z_q <= 1'b0;
        end else begin
            if (accept) begin
                gid  <= rdy1;
                op_q <= rdy1 ? bus.req1_op : bus.req0_op;
                a_q  <= rdy1 ? bus.req1_a  : bus.req0_a;
                b_q  <= rdy1 ? bus.req1_b  : bus.req0_b;
            end
            if (state == EXEC) begin
                rsp_o_q <= bus.alu_o;
                rsp_c_q <= bus.alu_c;
                rsp_z_q <= bus.alu_z;
            end
            if (rsp_hs) begin
                ptr <= !gid;
            end
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_o      = rsp_o_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp0_valid = (state == RESP) && !gid;
    assign bus.rsp1_valid = (state == RESP) && gid;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   npass;
    int   ntotal;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU
    logic [8:0] alu_r;
    always_comb begin
        alu_r = 9'd0;
        case (bus.alu_op)
            2'b00:   alu_r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            2'b01:   alu_r = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            2'b10:   alu_r = {1'b0, bus.alu_a & bus.alu_b};
            default: alu_r = {1'b0, bus.alu_a | bus.alu_b};
        endcase
    end
    assign bus.alu_o = alu_r[7:0];
    assign bus.alu_c = alu_r[8];
    assign bus.alu_z = (alu_r[7:0] == 8'h00);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_op = 2'b00; bus.req1_op = 2'b00;
        bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        ntotal++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else npass++;
        ntotal++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) $display("FAIL reset_rspv got %b want 00", {bus.rsp0_valid, bus.rsp1_valid}); else npass++;
        ntotal++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 18'd0) $display("FAIL reset_alu got %h want 0", {bus.alu_op, bus.alu_a, bus.alu_b}); else npass++;
        ntotal++; if ({bus.rsp_o, bus.rsp_c, bus.rsp_z} !== 10'd0) $display("FAIL reset_rsp got %h want 0", {bus.rsp_o, bus.rsp_c, bus.rsp_z}); else npass++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_add;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 8'hF0; bus.req0_b = 8'h20;
        @(negedge clk);
        ntotal++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL add_ready got %b want 10", {bus.req0_ready, bus.req1_ready}); else npass++;
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        ntotal++; if ({bus.busy, bus.rsp0_valid} !== 2'b10) $display("FAIL add_exec got %b want 10", {bus.busy, bus.rsp0_valid}); else npass++;
        ntotal++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {2'b00, 8'hF0, 8'h20}) $display("FAIL add_alu got %h want 0f020", {bus.alu_op, bus.alu_a, bus.alu_b}); else npass++;
        tick();
        @(negedge clk);
        ntotal++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10) $display("FAIL add_rspv got %b want 10", {bus.rsp0_valid, bus.rsp1_valid}); else npass++;
        ntotal++; if ({bus.rsp_o, bus.rsp_c, bus.rsp_z} !== {8'h10, 1'b1, 1'b0}) $display("FAIL add_rsp got %h want %h", {bus.rsp_o, bus.rsp_c, bus.rsp_z}, {8'h10, 1'b1, 1'b0}); else npass++;
        tick();
        @(negedge clk);
        ntotal++; if ({bus.busy, bus.rsp0_valid} !== 2'b00) $display("FAIL add_done got %b want 00", {bus.busy, bus.rsp0_valid}); else npass++;
        ntotal++; if (bus.alu_a !== 8'hF0) $display("FAIL add_hold got %h want f0", bus.alu_a); else npass++;
    endtask

    task automatic test_sub_zero;
        tick();
        bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_a = 8'h33; bus.req1_b = 8'h33;
        @(negedge clk);
        ntotal++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) $display("FAIL subz_ready got %b want 01", {bus.req0_ready, bus.req1_ready}); else npass++;
        tick();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        ntotal++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) $display("FAIL subz_exec got %b want 00", {bus.rsp0_valid, bus.rsp1_valid}); else npass++;
        tick();
        @(negedge clk);
        ntotal++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b01) $display("FAIL subz_rspv got %b want 01", {bus.rsp0_valid, bus.rsp1_valid}); else npass++;
        ntotal++; if ({bus.rsp_o, bus.rsp_c, bus.rsp_z} !== {8'h00, 1'b0, 1'b1}) $display("FAIL subz_rsp got %h want %h", {bus.rsp_o, bus.rsp_c, bus.rsp_z}, {8'h00, 1'b0, 1'b1}); else npass++;
        tick();
    endtask

    task automatic test_contention;
        logic [7:0] exp_o;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_a = 8'h0F; bus.req0_b = 8'hFF;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 8'h0F; bus.req1_b = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            exp_o = (i % 2 == 0) ? 8'h0F : 8'hFF;
            @(negedge clk);
            ntotal++;
            if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL cont_grant%0d got %b", i, {bus.req0_ready, bus.req1_ready});
            else npass++;
            tick();
            @(negedge clk);
            ntotal++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL cont_exec%0d ready got %b want 00", i, {bus.req0_ready, bus.req1_ready}); else npass++;
            tick();
            @(negedge clk);
            ntotal++;
            if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_o} !== {(i % 2 == 0), (i % 2 == 1), exp_o})
                $display("FAIL cont_rsp%0d got %h want %h", i, {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_o}, {(i % 2 == 0), (i % 2 == 1), exp_o});
            else npass++;
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_borrow;
        tick();
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        @(negedge clk);
        ntotal++; if (bus.rsp0_valid !== 1'b1) $display("FAIL borrow_rspv got %b want 1", bus.rsp0_valid); else npass++;
        ntotal++; if ({bus.rsp_o, bus.rsp_c, bus.rsp_z} !== {8'hFF, 1'b1, 1'b0}) $display("FAIL borrow_rsp got %h want %h", {bus.rsp_o, bus.rsp_c, bus.rsp_z}, {8'hFF, 1'b1, 1'b0}); else npass++;
        tick();
    endtask

    task automatic test_backpressure;
        bus.rsp0_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 8'h10; bus.req1_b = 8'h10;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ntotal++;
            if ({bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, bus.busy, bus.rsp_o} !== {4'b1001, 8'h03})
                $display("FAIL bp_hold%0d got %h want %h", i, {bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, bus.busy, bus.rsp_o}, {4'b1001, 8'h03});
            else npass++;
            tick();
        end
        bus.rsp0_ready = 1'b1;
        tick();
        @(negedge clk);
        ntotal++; if ({bus.busy, bus.rsp0_valid, bus.req1_ready} !== 3'b001) $display("FAIL bp_release got %b want 001", {bus.busy, bus.rsp0_valid, bus.req1_ready}); else npass++;
        bus.req1_valid = 1'b0;
        tick();
        @(negedge clk);
        ntotal++; if (bus.busy !== 1'b0) $display("FAIL bp_nogrant got %b want 0", bus.busy); else npass++;
        tick();
    endtask

    task automatic test_reset_exec;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 8'h55; bus.req0_b = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 8'h55; bus.req1_b = 8'h22;
        tick();
        @(negedge clk);
        ntotal++; if ({bus.busy, bus.alu_a} !== {1'b1, 8'h55}) $display("FAIL rx_exec got %h want 155", {bus.busy, bus.alu_a}); else npass++;
        rst = 1'b1;
        #1;
        ntotal++; if ({bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 5'b00000) $display("FAIL rx_ctrl got %b want 00000", {bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}); else npass++;
        ntotal++; if ({bus.alu_a, bus.alu_b, bus.rsp_o} !== 24'd0) $display("FAIL rx_data got %h want 0", {bus.alu_a, bus.alu_b, bus.rsp_o}); else npass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            ntotal++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) $display("FAIL rx_norsp%0d got %b want 00", i, {bus.rsp0_valid, bus.rsp1_valid}); else npass++;
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        ntotal++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL rx_first got %b want 10", {bus.req0_ready, bus.req1_ready}); else npass++;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        test_reset();
        test_add();
        test_sub_zero();
        test_contention();
        test_borrow();
        test_backpressure();
        test_reset_exec();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 8 bits to match the shared ALU.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester n operation accepted this cycle.
REQ-006 req0_op / req1_op  input  2 each  ALU opcode: 00 add, 01 sub, 10 and, 11 or.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
REQ-008 alu_op  output  2 / alu_a, alu_b  output  8 each  registered drive to the combinational ALU.
REQ-009 alu_o  input  8 / alu_c  input  1 / alu_z  input  1  ALU result, carry/borrow, zero flag.
REQ-010 rsp0_valid / rsp1_valid  output  1 each  result available for requester n.
REQ-011 rsp0_ready / rsp1_ready  input  1 each  requester n consumes result.
REQ-012 rsp_o  output  8 / rsp_c, rsp_z  output  1 each  shared result bus, meaningful only while a rsp valid is high.
REQ-013 busy  output  1  high in any state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; exactly one transaction in flight at a time.
REQ-015 In IDLE, grant SHALL go to the sole valid requester; if both valid, to the requester named by priority pointer ptr.
REQ-016 reqN_ready SHALL be combinational, high only in IDLE, only for the granted requester, and only while its valid is high; both readys never high together.
REQ-017 On a valid&ready cycle the block SHALL latch op, a, b and grant id into alu_op/alu_a/alu_b/gid and go to EXEC next cycle.
REQ-018 In EXEC (exactly one cycle) the block SHALL capture alu_o, alu_c, alu_z into rsp_o, rsp_c, rsp_z and go to RESP.
REQ-019 In RESP, rsp<gid>_valid SHALL be high and the other rsp valid low; rsp bus SHALL hold stable until the handshake.
REQ-020 On rsp<gid>_valid & rsp<gid>_ready the block SHALL return to IDLE and set ptr to the non-granted requester; rsp_ready of the non-granted requester SHALL be ignored.
REQ-021 Latency: accept in cycle N -> rsp valid from cycle N+2; with rsp_ready held high, new accept earliest at N+3 (one op per 3 cycles).
REQ-022 alu_op/alu_a/alu_b SHALL hold their last latched values outside EXEC; flags are pass-through of ALU (c = bit 8 of 9-bit result, sub borrow appears as c=1).
REQ-023 A requester dropping valid in IDLE before being granted SHALL not be serviced; requests SHALL not be queued.
REQ-024 Back-to-back contention SHALL alternate strictly 0,1,0,1 while both keep valid high.

Reset
REQ-025 rst high SHALL immediately (asynchronously) force state IDLE, ptr=0, gid=0, alu_op=00, alu_a=alu_b=0, rsp_o=0, rsp_c=0, rsp_z=0; all valid/ready/busy outputs low.
REQ-026 Reset mid-transaction SHALL abort it with no response issued; first post-reset grant with both valid SHALL go to req0.

Verification
REQ-027 Single add: req0 op=00 a=8'hF0 b=8'h20 -> req0_ready in accept cycle, rsp0_valid 2 cycles later, rsp_o=8'h10 c=1 z=0.
REQ-028 Subtract zero: req1 op=01 a=8'h33 b=8'h33 -> rsp1_valid, rsp_o=8'h00 c=0 z=1; rsp0_valid stays 0.
REQ-029 Contention: both valid continuously, req0 and=8'h0F&8'hFF, req1 or=8'h0F|8'hF0, rsp_ready=1 -> grants 0,1,0,1 at 3-cycle spacing; results 8'h0F and 8'hFF.
REQ-030 Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp_o stable, req1_ready stays 0, busy=1; release -> IDLE next cycle.
REQ-031 Borrow: req0 sub a=8'h01 b=8'h02 -> rsp_o=8'hFF c=1 z=0.
REQ-032 Reset in EXEC: assert rst mid-EXEC -> outputs cleared same cycle, no rsp valid ever, next contention grants req0 first.
